// File: rtl/parity_err_pkg.sv
// Shared types and default parameters for the parity error collector.
// FSM state encoding lives here so the bench and RTL agree on it.
package parity_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_FATAL  = 2'd2
    } state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int THRESH_DEF    = 4;
    localparam int RAIL_FILT_DEF = 2;

endpackage

// File: rtl/parity_rail_chk.sv
// Dual-rail consistency checker: flags a sticky fault once ERR == ERR_B
// has persisted for RAIL_FILT consecutive cycles.
module parity_rail_chk
    import parity_err_pkg::*;
#(
    parameter int RAIL_FILT = RAIL_FILT_DEF
) (
    input  logic ACLK,
    input  logic RESET_ACLK,
    input  logic ERR,
    input  logic ERR_B,
    input  logic CLR,
    output logic trip,
    output logic fault
);

    localparam int RW = $clog2(RAIL_FILT + 1);
    localparam logic [RW-1:0] LAST = RW'(RAIL_FILT - 1);

    logic [RW-1:0] run;
    logic          mismatch;

    assign mismatch = (ERR == ERR_B);

    // trip fires on the cycle the run completes, so the FSM can
    // enter FATAL on the same edge the sticky flag sets.
    assign trip = mismatch && !CLR && (run >= LAST);

    // Mismatch run length (saturating) and the sticky fault flag.
    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            run   <= '0;
            fault <= 1'b0;
        end else if (CLR) begin
            run   <= '0;
            fault <= 1'b0;
        end else if (mismatch) begin
            if (run < LAST) begin
                run <= run + 1'b1;
            end
            if (trip) begin
                fault <= 1'b1;
            end
        end else begin
            run <= '0;
        end
    end

endmodule

// File: rtl/parity_err_collector.sv
// Parity error collector: counts valid error cycles, raises an
// acknowledged interrupt and escalates to a sticky fatal state.
module parity_err_collector
    import parity_err_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int THRESH    = THRESH_DEF,
    parameter int RAIL_FILT = RAIL_FILT_DEF
) (
    input  logic             ACLK,
    input  logic             RESET_ACLK,
    input  logic             ERR,
    input  logic             ERR_B,
    input  logic             IRQ_ACK,
    input  logic             CLR,
    output logic             O_IRQ,
    output logic             O_FATAL,
    output logic             O_RAIL_FAULT,
    output logic             O_ERR_STICKY,
    output logic [CNT_W-1:0] O_ERR_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic             err_valid;
    logic             rail_trip;
    logic             rail_fault;

    assign err_valid = ERR && !ERR_B;

    parity_rail_chk #(
        .RAIL_FILT (RAIL_FILT)
    ) u_rail_chk (
        .ACLK       (ACLK),
        .RESET_ACLK (RESET_ACLK),
        .ERR        (ERR),
        .ERR_B      (ERR_B),
        .CLR        (CLR),
        .trip       (rail_trip),
        .fault      (rail_fault)
    );

    // Saturating error counter and the "seen an error" flag.
    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (CLR) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (err_valid) begin
            sticky <= 1'b1;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: CLR beats rail fault beats ACK beats error; the
    // ACK decision uses the count before this cycle's increment.
    always_comb begin
        state_nxt = state;
        if (CLR) begin
            state_nxt = ST_IDLE;
        end else if (rail_trip) begin
            state_nxt = ST_FATAL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (err_valid) begin
                        state_nxt = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (IRQ_ACK) begin
                        state_nxt = (cnt >= THR) ? ST_FATAL : ST_IDLE;
                    end
                end
                ST_FATAL: begin
                    state_nxt = ST_FATAL;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        O_IRQ   = 1'b0;
        O_FATAL = 1'b0;
        case (state)
            ST_REPORT: O_IRQ   = 1'b1;
            ST_FATAL:  O_FATAL = 1'b1;
            default: begin
                O_IRQ   = 1'b0;
                O_FATAL = 1'b0;
            end
        endcase
    end

    assign O_ERR_CNT    = cnt;
    assign O_ERR_STICKY = sticky;
    assign O_RAIL_FAULT = rail_fault;

endmodule

// File: tb/tb_parity_err_collector.sv
// Bench for parity_err_collector: table of per-cycle vectors checked
// through a scoreboard queue, plus reset and saturation sequences.
module tb_parity_err_collector;

    logic       ACLK = 1'b0;
    logic       RESET_ACLK;
    logic       ERR, ERR_B, IRQ_ACK, CLR;
    logic       irq, fatal, rail, sticky;
    logic [7:0] cnt;
    logic       s_irq, s_fatal, s_rail, s_sticky;
    logic [2:0] s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       err;
        logic       err_b;
        logic       ack;
        logic       clr;
        logic [7:0] cnt;
        logic       irq;
        logic       fatal;
        logic       rail;
        logic       sticky;
    } vec_t;

    vec_t       tbl[$];
    logic [11:0] sb[$];
    logic [2:0]  sb_sat[$];

    always #5 ACLK = ~ACLK;

    parity_err_collector dut (
        .ACLK         (ACLK),
        .RESET_ACLK   (RESET_ACLK),
        .ERR          (ERR),
        .ERR_B        (ERR_B),
        .IRQ_ACK      (IRQ_ACK),
        .CLR          (CLR),
        .O_IRQ        (irq),
        .O_FATAL      (fatal),
        .O_RAIL_FAULT (rail),
        .O_ERR_STICKY (sticky),
        .O_ERR_CNT    (cnt)
    );

    parity_err_collector #(.CNT_W(3)) dut_sat (
        .ACLK         (ACLK),
        .RESET_ACLK   (RESET_ACLK),
        .ERR          (ERR),
        .ERR_B        (ERR_B),
        .IRQ_ACK      (IRQ_ACK),
        .CLR          (CLR),
        .O_IRQ        (s_irq),
        .O_FATAL      (s_fatal),
        .O_RAIL_FAULT (s_rail),
        .O_ERR_STICKY (s_sticky),
        .O_ERR_CNT    (s_cnt)
    );

    function automatic logic [11:0] obs();
        return {cnt, irq, fatal, rail, sticky};
    endfunction

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d irq/fatal/rail/sticky=%b, want cnt=%0d irq/fatal/rail/sticky=%b",
                     name, act[11:4], act[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic add(input logic e, input logic eb, input logic a,
                       input logic c, input int n, input logic i,
                       input logic f, input logic r, input logic s);
        tbl.push_back({e, eb, a, c, 8'(n), i, f, r, s});
    endtask

    task automatic step(input logic e, input logic eb, input logic a,
                        input logic c, input logic [11:0] exp,
                        input string name);
        ERR = e; ERR_B = eb; IRQ_ACK = a; CLR = c;
        sb.push_back(exp);
        @(posedge ACLK);
        #1;
        check(name, obs(), sb.pop_front());
    endtask

    task automatic step_sat(input logic e, input logic [2:0] exp,
                            input string name);
        ERR = e; ERR_B = ~e; IRQ_ACK = 1'b0; CLR = 1'b0;
        sb_sat.push_back(exp);
        @(posedge ACLK);
        #1;
        check(name, {9'b0, s_cnt}, {9'b0, sb_sat.pop_front()});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // err eb ack clr | cnt irq fatal rail sticky
        add(0,1,0,0, 0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,1);
        add(0,1,1,0, 1,0,0,0,1);
        add(1,0,0,0, 2,1,0,0,1);
        add(1,0,0,0, 3,1,0,0,1);
        add(1,0,1,0, 4,0,0,0,1);
        add(0,1,0,0, 4,0,0,0,1);
        add(1,0,0,0, 5,1,0,0,1);
        add(0,1,1,0, 5,0,1,0,1);
        add(1,0,0,0, 6,0,1,0,1);
        add(0,1,1,0, 6,0,1,0,1);
        add(1,0,0,1, 0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(1,1,0,0, 0,0,1,1,0);
        add(0,1,0,0, 0,0,1,1,0);
        add(0,1,1,0, 0,0,1,1,0);
        add(0,1,0,1, 0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,1);
        add(1,0,0,0, 2,1,0,0,1);
        add(1,0,0,0, 3,1,0,0,1);
        add(1,0,0,0, 4,1,0,0,1);
        add(0,1,1,0, 4,0,1,0,1);
        add(1,0,0,0, 5,0,1,0,1);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,1);
        add(1,1,0,0, 1,1,0,0,1);
        add(0,0,0,0, 1,0,1,1,1);

        RESET_ACLK = 1'b1;
        ERR = 1'b0; ERR_B = 1'b1; IRQ_ACK = 1'b0; CLR = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("reset_state", obs(), 12'h000);
        RESET_ACLK = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].err, tbl[i].err_b, tbl[i].ack, tbl[i].clr,
                 {tbl[i].cnt, tbl[i].irq, tbl[i].fatal,
                  tbl[i].rail, tbl[i].sticky},
                 $sformatf("row%0d", i));
        end

        // Asynchronous reset while FATAL with rail fault set.
        ERR = 1'b0; ERR_B = 1'b1;
        RESET_ACLK = 1'b1;
        #1;
        check("async_reset_fatal", obs(), 12'h000);
        #2;
        RESET_ACLK = 1'b0;
        @(posedge ACLK);
        #1;
        step(1, 0, 0, 0, {8'd1, 4'b1001}, "post_reset_err");

        // Saturation on the 3-bit instance.
        step(0, 1, 0, 1, 12'h000, "clr_before_sat");
        for (int i = 0; i < 10; i++) begin
            step_sat(1'b1, (i + 1 > 7) ? 3'd7 : 3'(i + 1),
                     $sformatf("sat%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
